// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential signed/unsigned multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width of the step counter that runs 0..length-1.
    function automatic int cnt_width(input int length);
        return (length > 2) ? $clog2(length) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_signed_abs_val.sv
// Conditional two's-complement negate: o_val = i_neg ? -i_val : i_val.
module abs_val #(
    parameter int W = 8
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/seq_mult_signed.sv
// Shift-and-add multiplier on operand magnitudes with a sign fix-up state,
// start/busy/done handshake and sign-magnitude display outputs.
module seq_mult_signed
    import seq_mult_pkg::*;
#(
    parameter int LENGTH     = 5,
    parameter int OUT_LENGTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [LENGTH-1:0]     multiplicand,
    input  logic [LENGTH-1:0]     multiplier,
    output logic                  busy,
    output logic                  done,
    output logic [2*LENGTH-1:0]   product,
    output logic [2*LENGTH-1:0]   magnitude,
    output logic                  negative,
    output logic                  overflow
);

    localparam int CW = cnt_width(LENGTH);
    localparam int PW = 2 * LENGTH;

    state_t              r_state;
    state_t              w_next;
    logic                r_sign;
    logic [LENGTH-1:0]   r_mcand;
    logic [LENGTH-1:0]   r_mplr;
    logic [LENGTH:0]     r_acc;
    logic [CW-1:0]       r_cnt;
    logic [PW-1:0]       r_product;
    logic [PW-1:0]       r_magnitude;
    logic                r_negative;
    logic                r_overflow;

    logic                w_neg_a;
    logic                w_neg_b;
    logic [LENGTH-1:0]   w_abs_a;
    logic [LENGTH-1:0]   w_abs_b;
    logic [LENGTH:0]     w_sum;
    logic [PW:0]         w_shift;
    logic [PW-1:0]       w_mag;
    logic [PW-1:0]       w_prod;
    logic                w_last;
    logic                w_ovf;

    assign w_neg_a = signed_mode & multiplicand[LENGTH-1];
    assign w_neg_b = signed_mode & multiplier[LENGTH-1];

    abs_val #(.W(LENGTH)) u_abs_a (
        .i_neg (w_neg_a),
        .i_val (multiplicand),
        .o_val (w_abs_a)
    );

    abs_val #(.W(LENGTH)) u_abs_b (
        .i_neg (w_neg_b),
        .i_val (multiplier),
        .o_val (w_abs_b)
    );

    // After the final shift the accumulator MSB is always zero, so the
    // full magnitude is the low LENGTH accumulator bits above the multiplier.
    assign w_sum   = r_mplr[0] ? (r_acc + {1'b0, r_mcand}) : r_acc;
    assign w_shift = {w_sum, r_mplr} >> 1;
    assign w_mag   = {r_acc[LENGTH-1:0], r_mplr};
    assign w_last  = (r_cnt == CW'(LENGTH - 1));
    assign w_ovf   = |(w_mag >> OUT_LENGTH);

    abs_val #(.W(PW)) u_neg_prod (
        .i_neg (r_sign),
        .i_val (w_mag),
        .o_val (w_prod)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) w_next = SIGN;
            end
            SIGN: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sign      <= 1'b0;
            r_mcand     <= '0;
            r_mplr      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_magnitude <= '0;
            r_negative  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign  <= signed_mode & (multiplicand[LENGTH-1] ^ multiplier[LENGTH-1]);
                        r_mcand <= w_abs_a;
                        r_mplr  <= w_abs_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                CALC: begin
                    r_acc  <= w_shift[PW:LENGTH];
                    r_mplr <= w_shift[LENGTH-1:0];
                    r_cnt  <= r_cnt + 1'b1;
                end
                SIGN: begin
                    r_magnitude <= w_mag;
                    r_product   <= w_prod;
                    r_negative  <= r_sign & (|w_mag);
                    r_overflow  <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign product   = r_product;
    assign magnitude = r_magnitude;
    assign negative  = r_negative;
    assign overflow  = r_overflow;

endmodule
